// File: rtl/ppu_pkg.sv
// ppu_pkg: state encoding, line-timing constants and helpers shared by the sprite evaluator.
package ppu_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, READ_Y, CHECK_Y, COPY1, COPY2, COPY3, DONE} eval_state_t;
  localparam int CLEAR_LAST = 64;
  localparam int EVAL_FIRST = 65;
  localparam int EVAL_LAST = 256;
  localparam int XFER_CYCLE = 257;
  localparam int PRERENDER_LINE = 261;
  localparam int VISIBLE_LAST = 239;
  localparam logic [7:0] OAM2_FILL = 8'hFF;
  localparam int SPR_SLOTS = 8;
  function automatic logic [SPR_SLOTS-1:0] valid_mask(input logic [3:0] cnt);
    logic [SPR_SLOTS-1:0] m;
    m = '0;
    for (int i = 0; i < SPR_SLOTS; i++) m[i] = 4'(i) < cnt;
    return m;
  endfunction
endpackage

// File: rtl/sprite_eval_if.sv
// sprite_eval_if: timing inputs, primary-OAM read bus, oam2 fetch port and per-line results.
interface sprite_eval_if;
  logic       render_en;
  logic [8:0] cycle;
  logic [8:0] scanline;
  logic       spr_size16;
  logic [7:0] oam_addr;
  logic [7:0] oam_data;
  logic [4:0] oam2_raddr;
  logic [7:0] oam2_rdata;
  logic [7:0] slot_valid;
  logic [3:0] spr_cnt;
  logic       spr0_line;
  logic       overflow;
  modport master (
    output render_en, cycle, scanline, spr_size16, oam_data, oam2_raddr,
    input  oam_addr, oam2_rdata, slot_valid, spr_cnt, spr0_line, overflow
  );
  modport slave (
    input  render_en, cycle, scanline, spr_size16, oam_data, oam2_raddr,
    output oam_addr, oam2_rdata, slot_valid, spr_cnt, spr0_line, overflow
  );
endinterface

// File: rtl/oam2_ram.sv
// oam2_ram: 32x8 secondary OAM, one write port, combinational read, reset fills with 0xFF.
module oam2_ram
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rdata
);
  logic [7:0] mem [32];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 32; i++) mem[i] <= OAM2_FILL;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sprite_eval.sv
// sprite_eval: per-scanline secondary-OAM clear, primary-OAM range scan and result transfer.
module sprite_eval
  import ppu_pkg::*;
#(
  parameter int NUM_SLOTS = SPR_SLOTS
) (
  input logic         clk,
  input logic         rst_n,
  sprite_eval_if.slave bus
);
  eval_state_t state, state_nx;
  logic [5:0] n;
  logic [3:0] found;
  logic       spr0_next, active, in_range, full, we;
  logic [4:0] waddr;
  logic [7:0] wdata;
  logic [8:0] diff;
  assign active   = bus.render_en && bus.scanline <= 9'(VISIBLE_LAST);
  assign diff     = bus.scanline - {1'b0, bus.oam_data};
  assign in_range = diff < (bus.spr_size16 ? 9'd16 : 9'd8);
  assign full     = found == 4'(NUM_SLOTS);
  assign wdata    = (state == IDLE || state == CLEAR) ? OAM2_FILL : bus.oam_data;
  oam2_ram u_oam2 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(bus.oam2_raddr), .rdata(bus.oam2_rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // The fill write for cycle 1 happens while still in IDLE, so CLEAR covers all 32 bytes.
  always_comb begin
    state_nx     = state;
    bus.oam_addr = '0;
    we           = 1'b0;
    waddr        = bus.cycle[5:1];
    case (state)
      IDLE: if (bus.cycle == 9'd1) begin
        state_nx = CLEAR;
        we       = 1'b1;
      end
      CLEAR: begin
        we       = bus.cycle[0];
        state_nx = bus.cycle == 9'(CLEAR_LAST) ? READ_Y : CLEAR;
      end
      READ_Y: begin
        bus.oam_addr = {n, 2'b00};
        state_nx     = CHECK_Y;
      end
      CHECK_Y: begin
        bus.oam_addr = {n, 2'b01};
        waddr        = {found[2:0], 2'b00};
        we           = in_range && !full;
        state_nx     = in_range ? (full ? DONE : COPY1) : (n == 6'd63 ? DONE : READ_Y);
      end
      COPY1: begin
        bus.oam_addr = {n, 2'b10};
        waddr        = {found[2:0], 2'b01};
        we           = 1'b1;
        state_nx     = COPY2;
      end
      COPY2: begin
        bus.oam_addr = {n, 2'b11};
        waddr        = {found[2:0], 2'b10};
        we           = 1'b1;
        state_nx     = COPY3;
      end
      COPY3: begin
        waddr    = {found[2:0], 2'b11};
        we       = 1'b1;
        state_nx = n == 6'd63 ? DONE : READ_Y;
      end
      default: ;
    endcase
    if (state != IDLE && bus.cycle == 9'(EVAL_LAST)) state_nx = DONE;
    if (state != IDLE && bus.cycle == 9'(XFER_CYCLE)) state_nx = IDLE;
    if (!active) begin
      state_nx = IDLE;
      we       = 1'b0;
    end
  end
  logic [3:0] spr_cnt_q;
  logic [7:0] slot_valid_q;
  logic       spr0_line_q, overflow_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n            <= '0;
      found        <= '0;
      spr0_next    <= 1'b0;
      spr_cnt_q    <= '0;
      slot_valid_q <= '0;
      spr0_line_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (bus.scanline == 9'(PRERENDER_LINE) && bus.cycle == 9'd1) begin
        overflow_q   <= 1'b0;
        spr_cnt_q    <= '0;
        slot_valid_q <= '0;
        spr0_line_q  <= 1'b0;
      end
      if (active) begin
        if (state == CLEAR && bus.cycle == 9'(CLEAR_LAST)) begin
          n         <= '0;
          found     <= '0;
          spr0_next <= 1'b0;
        end
        if (state == CHECK_Y && in_range && full) overflow_q <= 1'b1;
        if (state == CHECK_Y && in_range && !full && n == 6'd0) spr0_next <= 1'b1;
        if (state == CHECK_Y && !in_range && n != 6'd63) n <= n + 6'd1;
        if (state == COPY3) begin
          found <= found + 4'd1;
          if (n != 6'd63) n <= n + 6'd1;
        end
        if (state != IDLE && bus.cycle == 9'(XFER_CYCLE)) begin
          spr_cnt_q    <= found;
          slot_valid_q <= valid_mask(found);
          spr0_line_q  <= spr0_next;
        end
      end
    end
  assign bus.spr_cnt    = spr_cnt_q;
  assign bus.slot_valid = slot_valid_q;
  assign bus.spr0_line  = spr0_line_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_sprite_eval.sv
// tb_sprite_eval: directed and random scanlines checked against a list-based sprite-selection model.
module tb_sprite_eval;
  import ppu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sprite_eval_if bus();
  sprite_eval dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  logic [7:0] oam_mem [256];
  always @(posedge clk) bus.oam_data <= oam_mem[bus.oam_addr];
  int checks = 0;
  int errors = 0;
  logic [3:0] exp_cnt = '0;
  logic [7:0] exp_valid = '0;
  logic exp_s0 = 1'b0;
  logic exp_ovf = 1'b0;
  logic [7:0] exp_oam2 [32];
  int hits[$];
  int nfound = 0;
  int ovf_cyc = -1;
  int psl = 300;
  int pc = -1;
  bit pen = 1'b0;
  bit alive = 1'b0;
  bit mon = 1'b0;
  always @(negedge clk) if (mon) begin
    checks++;
    if ({bus.spr_cnt, bus.slot_valid, bus.spr0_line, bus.overflow} !== {exp_cnt, exp_valid, exp_s0, exp_ovf}) begin
      errors++;
      $display("FAIL outputs t=%0t cnt/valid/s0/ovf got %0d/%h/%b/%b want %0d/%h/%b/%b", $time,
               bus.spr_cnt, bus.slot_valid, bus.spr0_line, bus.overflow, exp_cnt, exp_valid, exp_s0, exp_ovf);
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask
  // Selection model: in-range list in OAM order; 9th hit is checked after 8 accepts (5 cycles) and the rest rejected (2 cycles).
  task automatic plan(input int sl, input bit sz);
    int h = sz ? 16 : 8;
    hits.delete();
    for (int i = 0; i < 64; i++) begin
      int d = sl - int'(oam_mem[4*i]);
      if (d >= 0 && d < h) hits.push_back(i);
    end
    nfound = hits.size() > 8 ? 8 : hits.size();
    ovf_cyc = hits.size() > 8 ? 66 + 40 + 2 * (hits[8] - 8) : -1;
    for (int a = 0; a < 32; a++) exp_oam2[a] = 8'hFF;
    for (int k = 0; k < nfound; k++)
      for (int b = 0; b < 4; b++) exp_oam2[4*k+b] = oam_mem[4*hits[k]+b];
  endtask
  task automatic step(input int sl, input int c, input bit en);
    @(posedge clk);
    #1;
    if (pc == 1) alive = pen && psl <= 239;
    else if (!pen) alive = 1'b0;
    if (psl == 261 && pc == 1) begin
      exp_cnt = '0; exp_valid = '0; exp_s0 = 1'b0; exp_ovf = 1'b0;
    end
    if (alive && pc == ovf_cyc) exp_ovf = 1'b1;
    if (alive && pc == 257) begin
      exp_cnt = 4'(nfound);
      exp_valid = 8'((1 << nfound) - 1);
      exp_s0 = nfound > 0 && hits[0] == 0;
    end
    bus.scanline = 9'(sl);
    bus.cycle = 9'(c);
    bus.render_en = en;
    psl = sl; pc = c; pen = en;
  endtask
  task automatic check_oam2(input string nm);
    for (int a = 0; a < 32; a++) begin
      bus.oam2_raddr = 5'(a);
      #1;
      chk($sformatf("%s oam2[%0d]", nm, a), 32'(bus.oam2_rdata), 32'(exp_oam2[a]));
    end
  endtask
  task automatic rd(input string nm, input int a, input logic [7:0] want);
    bus.oam2_raddr = 5'(a);
    #1;
    chk(nm, 32'(bus.oam2_rdata), 32'(want));
  endtask
  task automatic run_line(input int sl, input bit sz, input int drop_at, input string nm);
    plan(sl, sz);
    bus.spr_size16 = sz;
    for (int c = 0; c <= 258; c++) step(sl, c, !(c >= drop_at && c < drop_at + 20));
    step(sl, 258, 1'b1);
    if (drop_at > 258) check_oam2(nm);
  endtask
  task automatic prerender();
    for (int c = 0; c <= 3; c++) step(261, c, 1'b1);
    step(261, 3, 1'b1);
  endtask
  task automatic fill_y(input logic [7:0] y);
    for (int i = 0; i < 64; i++) begin
      oam_mem[4*i] = y;
      oam_mem[4*i+1] = 8'(i);
      oam_mem[4*i+2] = 8'(i + 64);
      oam_mem[4*i+3] = 8'(i + 128);
    end
  endtask
  task automatic rand_oam(input int sl, input int dens);
    for (int i = 0; i < 64; i++) begin
      int y = ($urandom_range(0, dens) == 0) ? sl - int'($urandom_range(0, 17)) : int'($urandom_range(0, 255));
      oam_mem[4*i] = y < 0 ? 8'hFF : 8'(y);
      for (int b = 1; b < 4; b++) oam_mem[4*i+b] = 8'($urandom);
    end
  endtask
  initial begin
    bus.render_en = 1'b0; bus.cycle = '0; bus.scanline = '0; bus.spr_size16 = 1'b0; bus.oam2_raddr = '0;
    fill_y(8'hFF);
    for (int a = 0; a < 32; a++) exp_oam2[a] = 8'hFF;
    mon = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("reset spr_cnt", 32'(bus.spr_cnt), 0);
    chk("reset overflow", 32'(bus.overflow), 0);
    chk("reset oam_addr", 32'(bus.oam_addr), 0);
    check_oam2("reset");
    run_line(10, 1'b0, 1000, "t1");
    chk("t1 spr_cnt", 32'(bus.spr_cnt), 0);
    chk("t1 slot_valid", 32'(bus.slot_valid), 0);
    fill_y(8'hF0);
    oam_mem[0] = 8'h0A; oam_mem[1] = 8'h21; oam_mem[2] = 8'h43; oam_mem[3] = 8'h80;
    run_line(12, 1'b0, 1000, "t2");
    rd("t2 y", 0, 8'h0A); rd("t2 tile", 1, 8'h21); rd("t2 attr", 2, 8'h43); rd("t2 x", 3, 8'h80);
    chk("t2 spr_cnt", 32'(bus.spr_cnt), 1);
    chk("t2 slot_valid", 32'(bus.slot_valid), 32'h01);
    chk("t2 spr0_line", 32'(bus.spr0_line), 1);
    fill_y(8'hF0);
    for (int i = 5; i <= 14; i++) oam_mem[4*i] = 8'd20;
    run_line(27, 1'b0, 1000, "t3");
    chk("t3 spr_cnt", 32'(bus.spr_cnt), 8);
    chk("t3 slot_valid", 32'(bus.slot_valid), 32'hFF);
    chk("t3 overflow", 32'(bus.overflow), 1);
    chk("t3 spr0_line", 32'(bus.spr0_line), 0);
    rd("t3 slot0 tile", 1, 8'd5); rd("t3 slot7 tile", 29, 8'd12);
    fill_y(8'hF0);
    run_line(239, 1'b0, 1000, "t3b");
    chk("t3 overflow held", 32'(bus.overflow), 1);
    prerender();
    chk("t3 overflow cleared", 32'(bus.overflow), 0);
    fill_y(8'hF0);
    oam_mem[28] = 8'd20;
    run_line(32, 1'b0, 1000, "t4a");
    chk("t4 8x8 sl32", 32'(bus.spr_cnt), 0);
    run_line(32, 1'b1, 1000, "t4b");
    chk("t4 8x16 sl32", 32'(bus.spr_cnt), 1);
    run_line(19, 1'b1, 1000, "t4c");
    chk("t4 8x16 sl19", 32'(bus.spr_cnt), 0);
    run_line(19, 1'b0, 1000, "t4d");
    chk("t4 8x8 sl19", 32'(bus.spr_cnt), 0);
    fill_y(8'hF0);
    for (int i = 0; i < 3; i++) oam_mem[4*i] = 8'd50;
    run_line(55, 1'b0, 1000, "t5a");
    chk("t5 pre spr_cnt", 32'(bus.spr_cnt), 3);
    oam_mem[8] = 8'hF0;
    run_line(55, 1'b0, 100, "t5b");
    chk("t5 held spr_cnt", 32'(bus.spr_cnt), 3);
    chk("t5 held slot_valid", 32'(bus.slot_valid), 32'h07);
    plan(55, 1'b0);
    for (int c = 0; c <= 68; c++) step(55, c, 1'b1);
    #1 rst_n = 1'b0;
    exp_cnt = '0; exp_valid = '0; exp_s0 = 1'b0; exp_ovf = 1'b0; alive = 1'b0; pc = -1;
    for (int a = 0; a < 32; a++) exp_oam2[a] = 8'hFF;
    #1;
    chk("t6 spr_cnt", 32'(bus.spr_cnt), 0);
    chk("t6 slot_valid", 32'(bus.slot_valid), 0);
    chk("t6 oam_addr", 32'(bus.oam_addr), 0);
    check_oam2("t6 reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_line(55, 1'b0, 1000, "t6b");
    chk("t6 after spr_cnt", 32'(bus.spr_cnt), 2);
    chk("t6 after spr0_line", 32'(bus.spr0_line), 1);
    for (int t = 0; t < 24; t++) begin
      int sl = $urandom_range(0, 239);
      rand_oam(sl, $urandom_range(1, 8));
      run_line(sl, 1'($urandom), $urandom_range(0, 4) == 0 ? int'($urandom_range(2, 250)) : 1000, $sformatf("rand%0d", t));
      if ($urandom_range(0, 3) == 0) prerender();
    end
    mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
